hsi_byte_rx: RTL and testbench

Serial front end of the HSI receive path: oversamples the asynchronous `rx` line, deserializes start/8-data/parity/stop characters, and delivers each byte with a parity status. It also detects the inter-frame idle gap and issues the frame-end strobe. Its outputs drive the downstream error checker's `d`, `d_rdy`, `pb_err` and `rx_frame_end` inputs.

---
 rtl/hsi_byte_rx_if.sv | 27 ++
 rtl/hsi_byte_rx.sv | 185 ++++++++++++++++++
 tb/tb_hsi_byte_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hsi_byte_rx_if.sv
// Serial receive-side bundle: the rx line in, delivered byte and status strobes out.
interface hsi_byte_rx_if;
  logic       rx;
  logic [7:0] d;
  logic       d_rdy;
  logic       pb_err;
  logic       stop_err;
  logic       rx_frame_end;

  modport master (
    output rx,
    input  d,
    input  d_rdy,
    input  pb_err,
    input  stop_err,
    input  rx_frame_end
  );

  modport slave (
    input  rx,
    output d,
    output d_rdy,
    output pb_err,
    output stop_err,
    output rx_frame_end
  );
endinterface

// File: rtl/hsi_byte_rx.sv
// HSI serial receive front end: oversampled start/8-data/parity/stop deserializer
// with parity and stop status plus inter-frame idle-gap detection.
module hsi_byte_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 1,
  parameter int GAP_BITS     = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  hsi_byte_rx_if.slave bus
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(GAP_CYC - 1);
  localparam logic             ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_sync;
  logic             w_rxs;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_perr;
  logic [GAP_W-1:0] r_gap;
  logic             r_in_frame;
  logic [7:0]       r_d;
  logic             r_d_rdy;
  logic             r_pb_err;
  logic             r_stop_err;
  logic             r_frame_end;

  logic w_half;
  logic w_full;
  logic w_cnt_clr;
  logic w_shift;
  logic w_par_load;
  logic w_deliver;
  logic w_gap_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.rx};
  end

  assign w_rxs  = r_sync[1];
  assign w_half = (r_cnt == HALF_M1);
  assign w_full = (r_cnt == BIT_M1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A low stop bit means the line is held in break; start detection waits for it to rise.
  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_shift    = 1'b0;
    w_par_load = 1'b0;
    w_deliver  = 1'b0;
    w_gap_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
          w_gap_clr = 1'b1;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          w_next    = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == 3'd7) w_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_full) begin
          w_cnt_clr  = 1'b1;
          w_par_load = 1'b1;
          w_next     = S_STOP;
        end
      end
      S_STOP: begin
        if (w_full) begin
          w_cnt_clr = 1'b1;
          w_deliver = 1'b1;
          w_next    = w_rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        w_gap_clr = 1'b1;
        if (w_rxs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_cnt <= '0;
    else if (w_cnt_clr || r_state == S_IDLE || r_state == S_BREAK)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      if (r_state == S_START) r_bit_idx <= '0;
      else if (w_shift)       r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift)    r_shift <= {w_rxs, r_shift[7:1]};
      if (w_par_load) r_perr  <= (^r_shift) ^ w_rxs ^ ODD;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_d        <= '0;
      r_d_rdy    <= 1'b0;
      r_pb_err   <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_d_rdy    <= w_deliver;
      r_pb_err   <= w_deliver & r_perr;
      r_stop_err <= w_deliver & ~w_rxs;
      if (w_deliver) r_d <= r_shift;
    end
  end

  // The gap only runs in IDLE after a delivered byte, so a frame end always trails a byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gap       <= '0;
      r_in_frame  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= 1'b0;
      if (w_deliver) r_in_frame <= 1'b1;
      if (w_gap_clr) begin
        r_gap <= '0;
      end else if (r_state == S_IDLE && r_in_frame) begin
        if (r_gap == GAP_M1) begin
          r_gap       <= '0;
          r_in_frame  <= 1'b0;
          r_frame_end <= 1'b1;
        end else begin
          r_gap <= r_gap + GAP_W'(1);
        end
      end
    end
  end

  assign bus.d            = r_d;
  assign bus.d_rdy        = r_d_rdy;
  assign bus.pb_err       = r_pb_err;
  assign bus.stop_err     = r_stop_err;
  assign bus.rx_frame_end = r_frame_end;

endmodule

// File: tb/tb_hsi_byte_rx.sv
// Directed plus randomized bench for hsi_byte_rx; expectations come from a
// cycle-level model of character timing built from bit periods and gap lengths.
module tb_hsi_byte_rx;

  localparam int C        = 16;
  localparam int GB       = 4;
  localparam int PAR_ODD  = 1;
  localparam int GAPCYC   = GB * C;
  // rx driven at cycle k: two sync flops, half-bit start sample, ten more bits, one cycle to the flop
  localparam int DRDY_OFS = 2 + C / 2 + 10 * C + 1;

  typedef struct {
    int         at;
    logic       rdy;
    logic [7:0] d;
    logic       pb;
    logic       se;
  } ev_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;

  hsi_byte_rx_if bus();

  hsi_byte_rx #(
    .CLKS_PER_BIT(C),
    .PARITY_ODD  (PAR_ODD),
    .GAP_BITS    (GB)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ev_t expQ[$];
  ev_t gotQ[$];
  int  expFe[$];
  int  gotFe[$];
  ev_t monEv;

  int  checks = 0;
  int  passed = 0;
  bit  idleValid = 1'b0;
  int  idleEntry = 0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.d_rdy || bus.pb_err || bus.stop_err) begin
        monEv.at  = cyc;
        monEv.rdy = bus.d_rdy;
        monEv.d   = bus.d;
        monEv.pb  = bus.pb_err;
        monEv.se  = bus.stop_err;
        gotQ.push_back(monEv);
      end
      if (bus.rx_frame_end) gotFe.push_back(cyc);
    end
  end

  task automatic waitCycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic goodParity(input logic [7:0] v);
    return (($countones(v) + 1) % 2) == PAR_ODD;
  endfunction

  // A start edge seen by the receiver at cycle t ends the pending idle window
  task automatic noteStart(input int t);
    if (idleValid && t >= idleEntry + GAPCYC) expFe.push_back(idleEntry + GAPCYC);
    idleValid = 1'b0;
  endtask

  task automatic finishIdle();
    if (idleValid) expFe.push_back(idleEntry + GAPCYC);
    idleValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic p, input logic stopBit);
    int  k;
    int  ones;
    ev_t e;
    k = cyc;
    noteStart(k + 2);
    ones  = $countones(data) + (p ? 1 : 0);
    e.at  = k + DRDY_OFS;
    e.rdy = 1'b1;
    e.d   = data;
    e.pb  = ((ones % 2) != PAR_ODD);
    e.se  = ~stopBit;
    expQ.push_back(e);
    idleValid = stopBit;
    idleEntry = e.at;
    bus.rx = 1'b0;
    waitCycles(C);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      waitCycles(C);
    end
    bus.rx = p;
    waitCycles(C);
    bus.rx = stopBit;
    waitCycles(C);
  endtask

  // Line rises: two sync flops, then one cycle to leave BREAK for IDLE
  task automatic releaseBreak();
    idleEntry = cyc + 3;
    idleValid = 1'b1;
    bus.rx = 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " byte count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      check({tag, " d_rdy cycle"}, gotQ[i].at, expQ[i].at);
      check({tag, " d_rdy"}, gotQ[i].rdy, expQ[i].rdy);
      check({tag, " d"}, gotQ[i].d, expQ[i].d);
      check({tag, " pb_err"}, gotQ[i].pb, expQ[i].pb);
      check({tag, " stop_err"}, gotQ[i].se, expQ[i].se);
    end
    check({tag, " frame_end count"}, gotFe.size(), expFe.size());
    for (int i = 0; i < expFe.size() && i < gotFe.size(); i++)
      check({tag, " frame_end cycle"}, gotFe[i], expFe[i]);
    expQ.delete();
    gotQ.delete();
    expFe.delete();
    gotFe.delete();
  endtask

  logic [7:0] b2b[7];
  logic [7:0] rb;
  logic       rp;

  initial begin
    bus.rx = 1'b1;
    n_rst  = 1'b0;
    waitCycles(3);
    check("reset d", bus.d, 8'h00);
    check("reset d_rdy", bus.d_rdy, 1'b0);
    check("reset pb_err", bus.pb_err, 1'b0);
    check("reset stop_err", bus.stop_err, 1'b0);
    check("reset frame_end", bus.rx_frame_end, 1'b0);
    n_rst = 1'b1;
    waitCycles(5);

    applyStimulus(8'hA5, 1'b1, 1'b1);
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("single");
    check("single d hold", bus.d, 8'hA5);

    applyStimulus(8'h3C, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("parity");

    b2b = '{8'hAA, 8'h01, 8'h00, 8'h02, 8'h11, 8'h22, 8'h5E};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(b2b[i], goodParity(b2b[i]), 1'b1);
      if (i == 2) waitCycles(2 * C);
    end
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("b2b");
    check("b2b d hold", bus.d, 8'h5E);

    bus.rx = 1'b0;
    waitCycles(5);
    bus.rx = 1'b1;
    waitCycles(GAPCYC + 40);
    checkOutput("glitch");

    applyStimulus(8'h55, goodParity(8'h55), 1'b0);
    waitCycles(40 * C);
    releaseBreak();
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("break");

    applyStimulus(8'h12, goodParity(8'h12), 1'b1);
    waitCycles(GAPCYC - 8);
    applyStimulus(8'h34, goodParity(8'h34), 1'b1);
    waitCycles(GAPCYC - 7);
    applyStimulus(8'h56, goodParity(8'h56), 1'b1);
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("gap edge");

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      applyStimulus(rb, rp, 1'b1);
      waitCycles($urandom_range(0, 6 * C));
    end
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("random");

    bus.rx = 1'b0;
    waitCycles(C);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b0;
      waitCycles(C);
    end
    bus.rx = 1'b1;
    waitCycles(C / 2);
    n_rst = 1'b0;
    waitCycles(2);
    check("midreset d", bus.d, 8'h00);
    check("midreset d_rdy", bus.d_rdy, 1'b0);
    check("midreset pb_err", bus.pb_err, 1'b0);
    check("midreset stop_err", bus.stop_err, 1'b0);
    check("midreset frame_end", bus.rx_frame_end, 1'b0);
    waitCycles(3);
    n_rst = 1'b1;
    waitCycles(10);
    applyStimulus(8'h81, goodParity(8'h81), 1'b1);
    waitCycles(GAPCYC + 20);
    finishIdle();
    checkOutput("after reset");
    check("after reset d", bus.d, 8'h81);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
